// File: rtl/arb_pkg.sv
// Shared constants, FSM state encoding and rotated-index helper for the 8-way round-robin arbiter.
package arb_pkg;

  localparam int N        = 8;
  localparam int IDX_W    = 3;
  localparam int MAX_HOLD = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // (base + offset) mod N; the 3-bit result wraps naturally.
  function automatic logic [IDX_W-1:0] rot_idx(input logic [IDX_W-1:0] base,
                                               input logic [IDX_W-1:0] offset);
    return base + offset;
  endfunction

endpackage

// File: rtl/priority_encoder_8to3.sv
// Combinational 8-to-3 priority encoder: the lowest set bit wins, valid when any bit is set.
module priority_encoder_8to3 (
  input  logic [7:0] in_vec,
  output logic [2:0] idx,
  output logic       valid
);

  always_comb begin
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (in_vec[i]) idx = 3'(i);
    end
  end

  assign valid = |in_vec;

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter, 8 requesters, registered grant 1 cycle after request; grant held until release/withdraw.
// Optional ARB_GRANT_TIMEOUT_EN forces release after MAX_HOLD cycles and pulses timeout.
module rr_arbiter_8
  import arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [N-1:0]     req,
  input  logic             release_gnt,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  state_t           state, state_n;
  logic [IDX_W-1:0] ptr, ptr_n, gnt_idx_n, base, off, pick;
  logic [N-1:0]     gnt_n, cand, rot;
  logic             gnt_valid_n, ending, forced, any, grant_new;

  // Rotate the candidates so the current priority position lands at bit 0.
  always_comb begin
    ending = (state == GRANT) && (release_gnt || !req[gnt_idx] || forced);
    cand   = req & ~(ending ? gnt : '0);
    base   = ending ? rot_idx(gnt_idx, 3'd1) : ptr;
    rot    = '0;
    for (int i = 0; i < N; i++) begin
      rot[i] = cand[rot_idx(base, 3'(i))];
    end
  end

  priority_encoder_8to3 u_enc (
    .in_vec (rot),
    .idx    (off),
    .valid  (any)
  );

  assign pick = rot_idx(base, off);

  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    gnt_n       = gnt;
    gnt_idx_n   = gnt_idx;
    gnt_valid_n = gnt_valid;
    grant_new   = 1'b0;
    case (state)
      IDLE: begin
        if (enable && any) begin
          grant_new = 1'b1;
          state_n   = GRANT;
        end
      end
      GRANT: begin
        if (ending) begin
          ptr_n = base;
          if (enable && any) begin
            grant_new = 1'b1;
          end else begin
            state_n     = IDLE;
            gnt_n       = '0;
            gnt_valid_n = 1'b0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if (grant_new) begin
      gnt_n        = '0;
      gnt_n[pick]  = 1'b1;
      gnt_idx_n    = pick;
      gnt_valid_n  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      gnt       <= gnt_n;
      gnt_idx   <= gnt_idx_n;
      gnt_valid <= gnt_valid_n;
    end
  end

`ifdef ARB_GRANT_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD);

  logic [CNT_W-1:0] hold_cnt;
  logic             timeout_q;

  // A forced end only counts when no natural end condition is present.
  assign forced = (state == GRANT) && (hold_cnt == CNT_W'(MAX_HOLD - 1)) &&
                  !release_gnt && req[gnt_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= forced;
      if (grant_new) hold_cnt <= '0;
      else if (state == GRANT) hold_cnt <= CNT_W'(hold_cnt + 1'b1);
    end
  end

  assign timeout = timeout_q;
`else
  assign forced  = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Bench for rr_arbiter_8: directed vectors, scan-based reference model checked every cycle, plus literal pins.
module tb_rr_arbiter_8;

`ifdef ARB_GRANT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int MAXH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] req = 8'h00;
  logic       rel = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int n_vec = 0;
  int n_bad = 0;
  bit armed = 1'b0;

  rr_arbiter_8 dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .req         (req),
    .release_gnt (rel),
    .gnt         (gnt),
    .gnt_idx     (gnt_idx),
    .gnt_valid   (gnt_valid),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: owner index (-1 = none), priority pointer, hold count.
  int owner, mptr, hold, nxt, old;
  bit m_to, idx_pinned, timed;

  function automatic int scan(input logic [7:0] r, input int start, input int excl);
    for (int k = 0; k < 8; k++) begin
      int j;
      j = (start + k) % 8;
      if (r[j] && j != excl) return j;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      owner = -1; mptr = 0; hold = 0; m_to = 1'b0; idx_pinned = 1'b1;
    end else begin
      m_to = 1'b0;
      if (owner < 0) begin
        if (enable) begin
          nxt = scan(req, mptr, -1);
          if (nxt >= 0) begin
            owner = nxt; hold = 0; idx_pinned = 1'b0;
          end
        end
      end else begin
        timed = TO_EN && (hold == MAXH - 1) && !rel && req[owner];
        if (rel || !req[owner] || timed) begin
          m_to  = timed;
          mptr  = (owner + 1) % 8;
          old   = owner;
          owner = -1;
          if (enable) begin
            nxt = scan(req, mptr, old);
            if (nxt >= 0) begin
              owner = nxt; hold = 0;
            end
          end
        end else begin
          hold++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("m_gnt_valid", 32'(gnt_valid), 32'(owner >= 0));
      chk("m_gnt", 32'(gnt), (owner >= 0) ? (32'd1 << owner) : 32'd0);
      if (owner >= 0) chk("m_gnt_idx", 32'(gnt_idx), 32'(owner));
      else if (idx_pinned) chk("m_gnt_idx_rst", 32'(gnt_idx), 32'd0);
      chk("m_timeout", 32'(timeout), 32'(m_to));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick();
    armed = 1'b1;
    tick();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_idx", 32'(gnt_idx), 32'h0);
    chk("rst_valid", 32'(gnt_valid), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);

    rst = 1'b0; enable = 1'b1; req = 8'b0010_0100;
    tick();
    chk("first_gnt", 32'(gnt), 32'h04);
    chk("first_idx", 32'(gnt_idx), 32'd2);
    chk("first_valid", 32'(gnt_valid), 32'd1);

    rel = 1'b1; tick(); rel = 1'b0;
    chk("b2b_idx5", 32'(gnt_idx), 32'd5);
    chk("b2b_gnt5", 32'(gnt), 32'h20);
    rel = 1'b1; tick(); rel = 1'b0;
    chk("b2b_idx2", 32'(gnt_idx), 32'd2);

    req = 8'b1000_0001; tick();
    chk("withdraw_idx7", 32'(gnt_idx), 32'd7);
    rel = 1'b1; tick(); rel = 1'b0;
    chk("wrap_idx0", 32'(gnt_idx), 32'd0);
    chk("wrap_gnt0", 32'(gnt), 32'h01);

    req = 8'b0001_0000; tick();
    chk("single_idx4", 32'(gnt_idx), 32'd4);
    rel = 1'b1; tick(); rel = 1'b0;
    chk("single_gap", 32'(gnt_valid), 32'd0);
    tick();
    chk("single_regrant_v", 32'(gnt_valid), 32'd1);
    chk("single_regrant_i", 32'(gnt_idx), 32'd4);

    req = 8'b0000_1000; tick();
    chk("en_idx3", 32'(gnt_idx), 32'd3);
    enable = 1'b0;
    repeat (3) tick();
    chk("en_hold_v", 32'(gnt_valid), 32'd1);
    chk("en_hold_i", 32'(gnt_idx), 32'd3);
    req = 8'hFF; rel = 1'b1; tick(); rel = 1'b0;
    chk("en_drop_v", 32'(gnt_valid), 32'd0);
    repeat (3) tick();
    chk("en_stay_idle", 32'(gnt_valid), 32'd0);
    enable = 1'b1; tick();
    chk("en_resume_idx4", 32'(gnt_idx), 32'd4);

    rst = 1'b1; tick();
    chk("midrst_gnt", 32'(gnt), 32'h0);
    chk("midrst_valid", 32'(gnt_valid), 32'h0);
    chk("midrst_idx", 32'(gnt_idx), 32'h0);
    rst = 1'b0; req = 8'h00; rel = 1'b1; tick(); rel = 1'b0;
    chk("idle_release", 32'(gnt_valid), 32'd0);
    req = 8'b0100_0010; tick();
    chk("post_rst_idx1", 32'(gnt_idx), 32'd1);
    req = 8'b0100_0000; tick();
    chk("withdraw_b2b_idx6", 32'(gnt_idx), 32'd6);
    enable = 1'b0; req = 8'h00; tick();
    chk("withdraw_idle", 32'(gnt_valid), 32'd0);
    req = 8'hFF; tick();
    chk("disabled_idle", 32'(gnt_valid), 32'd0);
    enable = 1'b1; tick();
    chk("ptr7_idx7", 32'(gnt_idx), 32'd7);

    rst = 1'b1; tick();
    rst = 1'b0; req = 8'b0000_0001; tick();
    chk("hold_start_idx", 32'(gnt_idx), 32'd0);
`ifdef ARB_GRANT_TIMEOUT_EN
    for (int c = 1; c < MAXH; c++) begin
      tick();
      chk("to_quiet", 32'(timeout), 32'd0);
    end
    tick();
    chk("to_pulse", 32'(timeout), 32'd1);
    chk("to_drop_valid", 32'(gnt_valid), 32'd0);
    tick();
    chk("to_pulse_end", 32'(timeout), 32'd0);
    chk("to_regrant", 32'(gnt_valid), 32'd1);
`else
    repeat (20) tick();
    chk("hold_forever_v", 32'(gnt_valid), 32'd1);
    chk("hold_no_timeout", 32'(timeout), 32'd0);
`endif
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
